fpdiv: RTL and testbench
========================

FPDIV -- requirements
Module: fpdiv

Interface
REQ-001 Parameters: none; format fixed to IEEE-754 single precision.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request; sampled only in IDLE.
REQ-005 dataa  input  32  dividend, IEEE-754 single.
REQ-006 datab  input  32  divisor, IEEE-754 single.
REQ-007 busy  output  1  high from the edge accepting start until the edge asserting done.
REQ-008 done  output  1  single-cycle pulse; result valid while done is high and held until the next done.
REQ-009 result  output  32  quotient {sign, exp[7:0], mant[22:0]}.

Function
REQ-010 States SHALL be IDLE, CHECK, DIV, NORM, DONE; all outputs SHALL be registered.
REQ-011 IDLE with start=1 at edge N: latch dataa/datab, assert busy, go to CHECK.
REQ-012 start while not in IDLE SHALL be ignored; latched operands SHALL NOT change.
REQ-013 CHECK (edge N+1): sign = a[31]^b[31]; exponent field 0 SHALL be treated as zero (denormals flushed); exponent field 255 = Inf/NaN class.
REQ-014 Special cases in CHECK SHALL load result, skip to DONE: either operand Inf/NaN -> 0x7FC00000; a zero and b zero -> 0x7FC00000; b zero, a nonzero -> {sign, 0xFF, 0}; a zero, b nonzero -> {sign, 0x00, 0}.
REQ-015 Normal operands in CHECK: e = ea - eb + 127 in a 10-bit signed register; remainder = {1'b0, 1, a[22:0]} (25 bits); divisor = {1, b[22:0]}; quotient cleared; iteration counter = 0.
REQ-016 DIV: one restoring step per cycle for exactly 25 cycles (edges N+2..N+26): if remainder >= divisor, subtract and shift in quotient bit 1, else shift in 0; remainder then shifts left one bit.
REQ-017 Quotient SHALL be 25 bits, q[24] weight 2^0; value lies in (0.5, 2).
REQ-018 NORM (edge N+27): if q[24]=1, mant = q[23:1], exp = e; else mant = q[22:0], exp = e - 1.
REQ-019 Rounding SHALL be truncation (round toward zero); remainder bits discarded.
REQ-020 NORM exp >= 255 -> {sign, 0xFF, 0}; exp <= 0 -> {sign, 0x00, 0}; otherwise {sign, exp[7:0], mant}.
REQ-021 DONE: done=1 for one cycle, busy=0, return to IDLE; start is not accepted in DONE.
REQ-022 Latency: normal path done high in the cycle after edge N+28; special path done high in the cycle after edge N+2.
REQ-023 Back-to-back: start may be asserted on the cycle done is high; it is accepted at the next edge once in IDLE.
REQ-024 Iteration counter SHALL be 5 bits and SHALL NOT wrap past 24.

Reset
REQ-025 reset=1 at any edge SHALL force IDLE, busy=0, done=0, result=0x00000000, counter=0, regardless of state.
REQ-026 reset SHALL take priority over start in the same cycle; a division in progress SHALL be abandoned with no done pulse.

Verification
REQ-027 a=0x40C00000 (6.0), b=0x40000000 (2.0), start pulse -> done after 29 cycles, result=0x40400000.
REQ-028 a=0x3F800000, b=0x40400000 (1/3) -> result=0x3EAAAAAA (truncated, not 0x3EAAAAAB).
REQ-029 a=0xBF800000, b=0x00000000 -> result=0xFF800000 with done 3 cycles after start; a=0, b=0 -> 0x7FC00000.
REQ-030 a=0x7F000000, b=0x00800000 -> 0x7F800000 (overflow); a=0x00800000, b=0x7F000000 -> 0x00000000 (underflow).
REQ-031 Start with new operands held high during DIV -> ignored; first result unchanged; second division starts only after done.
REQ-032 Reset asserted 10 cycles into DIV -> busy=0, done never pulses, result=0; a subsequent 6.0/2.0 -> 0x40400000.

Source files
------------

// File: rtl/fpdiv.sv
// Multi-cycle IEEE-754 single-precision divider: restoring mantissa division,
// one quotient bit per cycle, truncating rounding, denormals flushed to zero.
module fpdiv (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] dataa,
  input  logic [31:0] datab,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  typedef enum logic [2:0] {IDLE, CHECK, DIV, NORM, DONE} state_t;

  state_t             state_q, state_d;
  logic [31:0]        a_q, a_d, b_q, b_d;
  logic signed [9:0]  exp_q, exp_d;
  logic [24:0]        rem_q, rem_d;
  logic [23:0]        div_q, div_d;
  logic [24:0]        quo_q, quo_d;
  logic [4:0]         cnt_q, cnt_d;
  logic [31:0]        res_q, res_d;
  logic [31:0]        result_q, result_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               sign;
  logic               a_zero, b_zero, a_inf, b_inf;
  logic [24:0]        trial;
  logic               ge;
  logic signed [9:0]  norm_exp;
  logic [22:0]        norm_mant;

  assign sign   = a_q[31] ^ b_q[31];
  assign a_zero = (a_q[30:23] == 8'h00);
  assign b_zero = (b_q[30:23] == 8'h00);
  assign a_inf  = (a_q[30:23] == 8'hFF);
  assign b_inf  = (b_q[30:23] == 8'hFF);

  assign ge    = (rem_q >= {1'b0, div_q});
  assign trial = rem_q - {1'b0, div_q};

  // q[24] carries weight 2^0; a clear bit means the quotient is below 1.0.
  assign norm_exp  = quo_q[24] ? exp_q : exp_q - 10'sd1;
  assign norm_mant = quo_q[24] ? quo_q[23:1] : quo_q[22:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      exp_q    <= '0;
      rem_q    <= '0;
      div_q    <= '0;
      quo_q    <= '0;
      cnt_q    <= '0;
      res_q    <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      exp_q    <= exp_d;
      rem_q    <= rem_d;
      div_q    <= div_d;
      quo_q    <= quo_d;
      cnt_q    <= cnt_d;
      res_q    <= res_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    exp_d    = exp_q;
    rem_d    = rem_q;
    div_d    = div_q;
    quo_d    = quo_q;
    cnt_d    = cnt_q;
    res_d    = res_q;
    result_d = result_q;
    busy_d   = busy_q;
    done_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = dataa;
          b_d     = datab;
          busy_d  = 1'b1;
          state_d = CHECK;
        end
      end
      CHECK: begin
        state_d = DONE;
        if (a_inf || b_inf) begin
          res_d = 32'h7FC0_0000;
        end else if (a_zero && b_zero) begin
          res_d = 32'h7FC0_0000;
        end else if (b_zero) begin
          res_d = {sign, 8'hFF, 23'd0};
        end else if (a_zero) begin
          res_d = {sign, 31'd0};
        end else begin
          exp_d   = $signed({2'b00, a_q[30:23]}) - $signed({2'b00, b_q[30:23]}) + 10'sd127;
          rem_d   = {2'b01, a_q[22:0]};
          div_d   = {1'b1, b_q[22:0]};
          quo_d   = '0;
          cnt_d   = '0;
          state_d = DIV;
        end
      end
      DIV: begin
        // The partial remainder stays below 2^24 after each step, so the shift is lossless.
        if (ge) begin
          rem_d = {trial[23:0], 1'b0};
          quo_d = {quo_q[23:0], 1'b1};
        end else begin
          rem_d = {rem_q[23:0], 1'b0};
          quo_d = {quo_q[23:0], 1'b0};
        end
        if (cnt_q == 5'd24) begin
          state_d = NORM;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      NORM: begin
        if (norm_exp >= 10'sd255) begin
          res_d = {sign, 8'hFF, 23'd0};
        end else if (norm_exp <= 10'sd0) begin
          res_d = {sign, 31'd0};
        end else begin
          res_d = {sign, norm_exp[7:0], norm_mant};
        end
        state_d = DONE;
      end
      DONE: begin
        result_d = res_q;
        done_d   = 1'b1;
        busy_d   = 1'b0;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_fpdiv.sv
// Self-checking bench for fpdiv: directed corner cases plus random operands
// compared against an integer-arithmetic model of truncating float division.
module tb_fpdiv;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] dataa;
  logic [31:0] datab;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int errors = 0;
  int checks = 0;

  fpdiv dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .dataa  (dataa),
    .datab  (datab),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: quotient = floor(ma * 2^24 / mb), then normalise and range-check.
  function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                          output bit special);
    int     ea, eb, e;
    longint ma, mb, q;
    logic   s;
    logic [22:0] mant;
    s  = a[31] ^ b[31];
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    special = 1'b1;
    if (ea == 255 || eb == 255) return 32'h7FC0_0000;
    if (ea == 0 && eb == 0)     return 32'h7FC0_0000;
    if (eb == 0)                return {s, 8'hFF, 23'd0};
    if (ea == 0)                return {s, 31'd0};
    special = 1'b0;
    ma = longint'({9'd1, a[22:0]});
    mb = longint'({9'd1, b[22:0]});
    q  = (ma << 24) / mb;
    e  = ea - eb + 127;
    if (q >= (longint'(1) << 24)) begin
      mant = 23'((q >> 1) & 64'h7F_FFFF);
    end else begin
      mant = 23'(q & 64'h7F_FFFF);
      e    = e - 1;
    end
    if (e >= 255) return {s, 8'hFF, 23'd0};
    if (e <= 0)   return {s, 31'd0};
    return {s, 8'(e), mant};
  endfunction

  // Pulse start for one edge, then count edges until done is seen (bounded).
  task automatic run_div(input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output int lat, output bit busy_ok);
    @(negedge clk);
    dataa = a;
    datab = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    busy_ok = busy;
    lat = 0;
    while (!done && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    res = result;
    if (busy) busy_ok = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    reset = 1'b1;
    start = 1'b1;
    dataa = 32'h40C0_0000;
    datab = 32'h4000_0000;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 32'h0) begin
      errors++;
      $display("FAIL reset_state: busy=%b done=%b result=%h, required 0 0 00000000", busy, done, result);
    end
    start = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_priority: busy=%b, required 0", busy);
    end
  endtask

  task automatic test_directed;
    logic [31:0] va [6] = '{32'h40C0_0000, 32'h3F80_0000, 32'hBF80_0000, 32'h0000_0000,
                            32'h7F00_0000, 32'h0080_0000};
    logic [31:0] vb [6] = '{32'h4000_0000, 32'h4040_0000, 32'h0000_0000, 32'h0000_0000,
                            32'h0080_0000, 32'h7F00_0000};
    logic [31:0] vr [6] = '{32'h4040_0000, 32'h3EAA_AAAA, 32'hFF80_0000, 32'h7FC0_0000,
                            32'h7F80_0000, 32'h0000_0000};
    int          vl [6] = '{28, 28, 2, 2, 28, 28};
    logic [31:0] res;
    int          lat;
    bit          bok;
    for (int unsigned i = 0; i < 6; i++) begin
      run_div(va[i], vb[i], res, lat, bok);
      checks++;
      if (res !== vr[i]) begin
        errors++;
        $display("FAIL directed_result[%0d]: got %h, required %h", i, res, vr[i]);
      end
      checks++;
      if (lat !== vl[i]) begin
        errors++;
        $display("FAIL directed_latency[%0d]: got %0d, required %0d", i, lat, vl[i]);
      end
      checks++;
      if (!bok) begin
        errors++;
        $display("FAIL directed_busy[%0d]: busy high after start=0/at done=1, required 1/0", i);
      end
    end
    repeat (3) @(negedge clk);
    checks++;
    if (done !== 1'b0 || result !== vr[5]) begin
      errors++;
      $display("FAIL result_hold: done=%b result=%h, required 0 %h", done, result, vr[5]);
    end
  endtask

  task automatic test_random;
    logic [31:0] a, b, res, exp_r;
    int          lat;
    bit          bok, sp;
    for (int unsigned i = 0; i < 40; i++) begin
      a = $urandom;
      b = $urandom;
      if (i % 8 == 3) a[30:23] = 8'h00;
      else if (i % 8 == 5) b[30:23] = 8'hFF;
      else begin
        a[30:23] = 8'($urandom_range(1, 254));
        b[30:23] = 8'($urandom_range(1, 254));
      end
      exp_r = ref_div(a, b, sp);
      run_div(a, b, res, lat, bok);
      checks++;
      if (res !== exp_r || lat !== (sp ? 2 : 28)) begin
        errors++;
        $display("FAIL random[%0d] %h/%h: got %h lat %0d, required %h lat %0d",
                 i, a, b, res, lat, exp_r, sp ? 2 : 28);
      end
    end
  endtask

  task automatic test_back_to_back;
    int lat;
    @(negedge clk);
    dataa = 32'h40C0_0000;
    datab = 32'h4000_0000;
    start = 1'b1;
    @(negedge clk);
    repeat (10) @(negedge clk);
    // New operands with start held high while the first division runs.
    dataa = 32'h3F80_0000;
    datab = 32'h4040_0000;
    lat = 0;
    while (!done && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (result !== 32'h4040_0000) begin
      errors++;
      $display("FAIL ignore_start: got %h, required 40400000", result);
    end
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_accept: busy=%b, required 1", busy);
    end
    lat = 0;
    while (!done && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (result !== 32'h3EAA_AAAA || lat !== 28) begin
      errors++;
      $display("FAIL b2b_second: got %h lat %0d, required 3eaaaaaa lat 28", result, lat);
    end
  endtask

  task automatic test_reset_abort;
    logic [31:0] res;
    int          lat;
    bit          bok, seen;
    @(negedge clk);
    dataa = 32'h40C0_0000;
    datab = 32'h4000_0000;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (11) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 32'h0) begin
      errors++;
      $display("FAIL abort_state: busy=%b done=%b result=%h, required 0 0 00000000", busy, done, result);
    end
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL abort_no_done: done pulsed=1, required 0");
    end
    run_div(32'h40C0_0000, 32'h4000_0000, res, lat, bok);
    checks++;
    if (res !== 32'h4040_0000 || lat !== 28) begin
      errors++;
      $display("FAIL abort_rerun: got %h lat %0d, required 40400000 lat 28", res, lat);
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    dataa = '0;
    datab = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
